// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the block-RAM access controller.
//   state_t        controller FSM states
//   DEPTH          RAM depth for the default address width
//   lat_cnt_width  width of the read-latency counter for a given latency
package bram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_t;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 6;
  localparam int unsigned DEPTH                 = 2 ** DEFAULT_ADDRESS_WIDTH;

  // Counter must hold 0..lat inclusive.
  function automatic int unsigned lat_cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/bram_access_controller_if.sv
// Client-side command/response channels of the block-RAM access controller.
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr/cmd_wdata   command address and write data
//   rsp_valid/rsp_ready  read-response handshake
//   rsp_data             read data
// master = client side, slave = controller side.
interface bram_access_controller_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 6
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]    cmd_wdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_access_controller_init_sweeper.sv
// Fill-sweep address counter.
//   clk, clr  clock and synchronous active-high reset
//   start     restart the sweep at address 0
//   step      advance to the next address (saturates at the last one)
//   addr      current sweep address
//   last      addr is the final RAM address
module bram_init_sweeper #(
  parameter int unsigned ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     step,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     last
);

  assign last = &addr;

  always_ff @(posedge clk) begin
    if (clr || start) begin
      addr <= '0;
    end else if (step && !last) begin
      addr <= addr + ADDRESS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bram_access_controller.sv
// Initiator-side front end for a single-port block RAM.
//   clk, clr      clock and synchronous active-high reset
//   fill_req      start a fill sweep (honoured only when idle)
//   busy          fill sweep in progress
//   bus           command/response channels (slave side)
//   ram_*         registered RAM control pins and RAM read data input
module bram_access_controller
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDRESS_WIDTH = 6,
  parameter int unsigned           READ_LATENCY  = 1,
  parameter bit                    INIT_EN       = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     fill_req,
  output logic                     busy,
  bram_access_controller_if.slave  bus,
  output logic                     ram_read_en,
  output logic                     ram_write_en,
  output logic                     ram_n_clr,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  localparam int unsigned LAT_W = lat_cnt_width(READ_LATENCY);

  state_t                   state, state_nxt;
  logic [LAT_W-1:0]         lat_cnt, lat_nxt;
  logic                     we_nxt, re_nxt, capture;
  logic [ADDRESS_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0]    din_nxt;
  logic                     sweep_start, sweep_step, sweep_last;
  logic [ADDRESS_WIDTH-1:0] sweep_addr;
  logic                     cmd_hs;

  bram_init_sweeper #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_sweeper (
    .clk  (clk),
    .clr  (clr),
    .start(sweep_start),
    .step (sweep_step),
    .addr (sweep_addr),
    .last (sweep_last)
  );

  assign busy          = (state == ST_INIT);
  // ram_n_clr is low only in the cycle(s) right after reset; gating ready
  // with it keeps cmd_ready at 0 there even when reset lands directly in IDLE.
  assign bus.cmd_ready = (state == ST_IDLE) && ram_n_clr;
  assign bus.rsp_valid = (state == ST_RD_RESP);
  assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_nxt   = state;
    lat_nxt     = lat_cnt;
    we_nxt      = 1'b0;
    re_nxt      = 1'b0;
    addr_nxt    = '0;
    din_nxt     = '0;
    capture     = 1'b0;
    sweep_start = 1'b0;
    sweep_step  = 1'b0;
    unique case (state)
      ST_INIT: begin
        we_nxt     = 1'b1;
        addr_nxt   = sweep_addr;
        din_nxt    = INIT_VALUE;
        sweep_step = 1'b1;
        if (sweep_last) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_hs) begin
          addr_nxt = bus.cmd_addr;
          if (bus.cmd_write) begin
            we_nxt  = 1'b1;
            din_nxt = bus.cmd_wdata;
          end else begin
            re_nxt    = 1'b1;
            lat_nxt   = '0;
            state_nxt = ST_RD_WAIT;
          end
        end else if (fill_req) begin
          sweep_start = 1'b1;
          state_nxt   = ST_INIT;
        end
      end
      ST_RD_WAIT: begin
        // First RD_WAIT edge is the RAM's sampling edge, so capture happens
        // READ_LATENCY edges after it.
        if (lat_cnt == LAT_W'(READ_LATENCY)) begin
          capture   = 1'b1;
          state_nxt = ST_RD_RESP;
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      ST_RD_RESP: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= INIT_EN ? ST_INIT : ST_IDLE;
      lat_cnt      <= '0;
      ram_read_en  <= 1'b0;
      ram_write_en <= 1'b0;
      ram_n_clr    <= 1'b0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
      bus.rsp_data <= '0;
    end else begin
      state        <= state_nxt;
      lat_cnt      <= lat_nxt;
      ram_read_en  <= re_nxt;
      ram_write_en <= we_nxt;
      ram_n_clr    <= 1'b1;
      ram_addr     <= addr_nxt;
      ram_data_in  <= din_nxt;
      if (capture) bus.rsp_data <= ram_data_out;
    end
  end

endmodule

// File: tb/tb_bram_access_controller.sv
module tb_bram_access_controller;

  localparam logic [31:0] FILL = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        fill_req = 1'b0;
  logic        busy;
  logic        ram_read_en, ram_write_en, ram_n_clr;
  logic [5:0]  ram_addr;
  logic [31:0] ram_data_in, ram_data_out;

  int n_vec = 0;
  int n_bad = 0;
  int rsp_seen = 0;

  bram_access_controller_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6)) bus ();

  bram_access_controller #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(6),
    .READ_LATENCY (1),
    .INIT_EN      (1'b1),
    .INIT_VALUE   (FILL)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .fill_req    (fill_req),
    .busy        (busy),
    .bus         (bus),
    .ram_read_en (ram_read_en),
    .ram_write_en(ram_write_en),
    .ram_n_clr   (ram_n_clr),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read latency 1.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_data_in;
    if (ram_read_en) ram_data_out <= mem[ram_addr];
  end

  always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_seen++;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [31:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check_vec("cmd_accept_timeout", 64'd0, 64'd1);
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
  endtask

  // Read one word, hold rsp_ready low for 'hold' extra cycles, then accept.
  task automatic do_read(input string tag, input logic [5:0] a, input int hold, input logic [31:0] exp);
    int lat = 1;
    int unstable = 0;
    bus.rsp_ready = 1'b0;
    send_cmd(1'b0, a, 32'd0);
    check_vec({tag, "_read_en"}, {ram_read_en, ram_addr}, {1'b1, a});
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check_vec({tag, "_latency"}, lat, 3);
    check_vec({tag, "_data"}, bus.rsp_data, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.cmd_ready !== 1'b0) unstable++;
    end
    if (hold > 0) check_vec({tag, "_hold_stable"}, unstable, 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check_vec({tag, "_rsp_done"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
  endtask

  // Starts in the first cycle of a fill (busy high, no write yet).
  task automatic fill_check(input string tag);
    int busy_cnt = 0;
    int wr_cnt = 0;
    int seq_bad = 0;
    int rdy_bad = 0;
    int rsp0 = rsp_seen;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (bus.cmd_ready !== 1'b0) rdy_bad++;
      end
      if (ram_write_en === 1'b1) begin
        if (ram_addr !== 6'(wr_cnt) || ram_data_in !== FILL) seq_bad++;
        wr_cnt++;
      end
      if (busy !== 1'b1 && ram_write_en !== 1'b1) break;
      step();
    end
    check_vec({tag, "_busy_cycles"}, busy_cnt, 64);
    check_vec({tag, "_write_count"}, wr_cnt, 64);
    check_vec({tag, "_write_seq"}, seq_bad, 0);
    check_vec({tag, "_ready_low"}, rdy_bad, 0);
    check_vec({tag, "_no_rsp"}, rsp_seen - rsp0, 0);
  endtask

  task automatic check_reset(input string tag);
    check_vec({tag, "_ram"}, {ram_read_en, ram_write_en, ram_n_clr, ram_addr, ram_data_in}, 41'd0);
    check_vec({tag, "_hs"}, {bus.cmd_ready, bus.rsp_valid, bus.rsp_data}, 34'd0);
    check_vec({tag, "_busy"}, busy, 1'b1);
  endtask

  initial begin
    int n;
    int rsp0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Power-on reset and initial fill.
    clr = 1'b1;
    step();
    check_reset("reset");
    clr = 1'b0;
    fill_check("init_fill");
    check_vec("n_clr_released", ram_n_clr, 1'b1);
    do_read("rd37", 6'd37, 0, FILL);

    // Write then immediate read of the same address.
    send_cmd(1'b1, 6'd20, 32'd10);
    check_vec("wr20_pins", {ram_write_en, ram_addr, ram_data_in}, {1'b1, 6'd20, 32'd10});
    do_read("rd20", 6'd20, 0, 32'd10);

    // Back-to-back writes.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_addr  = 6'(5 + i);
      bus.cmd_wdata = 32'(1 + i);
      step();
      check_vec($sformatf("b2b_wr%0d", i), {ram_write_en, ram_addr, ram_data_in},
                {1'b1, 6'(5 + i), 32'(1 + i)});
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    step();
    check_vec("b2b_wr_end", {ram_write_en, ram_addr, ram_data_in}, 39'd0);
    do_read("rd5", 6'd5, 0, 32'd1);
    do_read("rd6", 6'd6, 0, 32'd2);
    do_read("rd7_held", 6'd7, 5, 32'd3);

    // Reset during RD_WAIT.
    rsp0 = rsp_seen;
    send_cmd(1'b0, 6'd20, 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_reset("clr_rdwait");

    // Reset mid-fill once the sweep counter reaches 30.
    n = 0;
    while (!(ram_write_en === 1'b1 && ram_addr === 6'd29) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check_vec("midfill_reach_timeout", 64'd0, 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_reset("clr_midfill");
    fill_check("refill");
    check_vec("aborted_read_no_rsp", rsp_seen - rsp0, 0);
    do_read("rd20_after_fill", 6'd20, 0, FILL);

    // fill_req collides with a write: the write wins.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 6'd9;
    bus.cmd_wdata = 32'h99;
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    check_vec("collide_write", {busy, ram_write_en, ram_addr, ram_data_in}, {1'b0, 1'b1, 6'd9, 32'h99});
    step();
    check_vec("collide_no_fill", busy, 1'b0);
    do_read("rd9", 6'd9, 0, 32'h99);

    // Lone fill_req.
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    fill_check("req_fill");
    do_read("rd9_filled", 6'd9, 0, FILL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
